// File: rtl/bl_pkg.sv
`default_nettype none
// ============================================================================
// Package     : bl_pkg
// Description : Shared sizes, gray_mode codes and read-FSM state encoding for
//               the backlight zone transmit scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package bl_pkg;

  localparam int ZONES = 360;  // 24x15 zones per frame
  localparam int DW    = 8;    // zone data width
  localparam int AW    = 9;    // zone index width, 2**AW >= ZONES

  localparam logic [1:0] GRAY_OPT    = 2'b01;
  localparam logic [1:0] GRAY_STATIC = 2'b10;
  localparam logic [1:0] GRAY_MAX    = 2'b11;

  // Index of the final zone of a frame, sized to the read address
  localparam logic [AW-1:0] LAST_IDX = AW'(ZONES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } rd_state_e;

endpackage : bl_pkg
`default_nettype wire

// File: rtl/bl_zone_dpram.sv
`default_nettype none
// ============================================================================
// Module      : bl_zone_dpram
// Description : Simple dual-port zone RAM, one write and one read port,
//               one-cycle registered read. Address is {bank, zone index};
//               each bank spans 2**AW entries of which ZONES are used.
// Revision    : 1.0 - initial release
// ============================================================================
module bl_zone_dpram
  import bl_pkg::*;
(
  input  logic          i_clk,
  input  logic          rst,
  input  logic          i_we,
  input  logic [AW:0]   i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW:0]   i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [0:(2**(AW+1))-1];
  logic [DW-1:0] r_rdata;

  // Write port: storage array is not reset
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read port: output register only loads on a read, so it holds between reads
  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule : bl_zone_dpram
`default_nettype wire

// File: rtl/bl_zone_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : bl_zone_tx_scheduler
// Description : Captures per-zone backlight values into a ping-pong buffer,
//               swaps banks on vsync and streams the completed frame over a
//               valid/ready link. Applies gray_mode changes on frame swaps.
// Revision    : 1.0 - initial release
// ============================================================================
module bl_zone_tx_scheduler
  import bl_pkg::*;
(
  input  logic          i_pix_clk,
  input  logic          rst,
  input  logic          zone_valid,
  input  logic [AW-1:0] zone_idx,
  input  logic [DW-1:0] zone_data,
  input  logic          vsync,
  input  logic [1:0]    mode_req,
  output logic [1:0]    gray_mode,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic [DW-1:0] tx_data,
  output logic          tx_sof,
  output logic          tx_eof,
  output logic          busy,
  output logic [7:0]    drop_cnt,
  output logic          idx_err
);

  rd_state_e     r_state;
  rd_state_e     w_state_nxt;
  logic          r_vsync_q;
  logic          r_wr_bank;
  logic          r_rd_bank;
  logic [AW-1:0] r_rd_addr;
  logic [1:0]    r_gray_mode;
  logic [7:0]    r_drop_cnt;
  logic          r_idx_err;

  logic          w_vs_edge;
  logic          w_idx_ok;
  logic          w_we;
  logic          w_swap;
  logic          w_drop;
  logic          w_rd_last;
  logic          w_accept;
  logic          w_re;
  logic          w_tx_valid;
  logic [DW-1:0] w_rdata;

  assign w_vs_edge = vsync & ~r_vsync_q;
  assign w_idx_ok  = (zone_idx < AW'(ZONES));
  assign w_we      = zone_valid & w_idx_ok;
  // A frame boundary is only honoured while the reader is free
  assign w_swap    = w_vs_edge & (r_state == ST_IDLE);
  assign w_drop    = w_vs_edge & (r_state != ST_IDLE);
  assign w_rd_last = (r_rd_addr == LAST_IDX);
  assign w_accept  = (r_state == ST_HOLD) & tx_ready;
  assign w_re      = (r_state == ST_FETCH);

  bl_zone_dpram u_ram (
    .i_clk   (i_pix_clk),
    .rst     (rst),
    .i_we    (w_we),
    .i_waddr ({r_wr_bank, zone_idx}),
    .i_wdata (zone_data),
    .i_re    (w_re),
    .i_raddr ({r_rd_bank, r_rd_addr}),
    .o_rdata (w_rdata)
  );

  // Delayed vsync for rising-edge detection
  always_ff @(posedge i_pix_clk or posedge rst) begin
    if (rst) begin
      r_vsync_q <= 1'b0;
    end else begin
      r_vsync_q <= vsync;
    end
  end

  // Bank swap: reader takes the bank just filled, writer moves to the other
  always_ff @(posedge i_pix_clk or posedge rst) begin
    if (rst) begin
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b1;
    end else if (w_swap) begin
      r_wr_bank <= ~r_wr_bank;
      r_rd_bank <= r_wr_bank;
    end
  end

  // Read address: restarts at zone 0 on a swap, advances on each accepted beat
  always_ff @(posedge i_pix_clk or posedge rst) begin
    if (rst) begin
      r_rd_addr <= '0;
    end else if (w_swap) begin
      r_rd_addr <= '0;
    end else if (w_accept && !w_rd_last) begin
      r_rd_addr <= r_rd_addr + 1'b1;
    end
  end

  // Gray mode follows the request only when a new frame is actually taken
  always_ff @(posedge i_pix_clk or posedge rst) begin
    if (rst) begin
      r_gray_mode <= GRAY_MAX;
    end else if (w_swap) begin
      r_gray_mode <= mode_req;
    end
  end

  // Saturating count of frame boundaries that arrived while the reader was busy
  always_ff @(posedge i_pix_clk or posedge rst) begin
    if (rst) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  // Sticky flag for out-of-range zone indices
  always_ff @(posedge i_pix_clk or posedge rst) begin
    if (rst) begin
      r_idx_err <= 1'b0;
    end else if (zone_valid && !w_idx_ok) begin
      r_idx_err <= 1'b1;
    end
  end

  // Read FSM state register
  always_ff @(posedge i_pix_clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Read FSM next state and stream valid
  always_comb begin
    w_state_nxt = r_state;
    w_tx_valid  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_vs_edge) begin
          w_state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: begin
        w_state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        w_tx_valid = 1'b1;
        if (tx_ready) begin
          w_state_nxt = w_rd_last ? ST_IDLE : ST_FETCH;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign gray_mode = r_gray_mode;
  assign tx_valid  = w_tx_valid;
  assign tx_data   = w_rdata;
  assign tx_sof    = w_tx_valid & (r_rd_addr == '0);
  assign tx_eof    = w_tx_valid & w_rd_last;
  assign busy      = (r_state != ST_IDLE);
  assign drop_cnt  = r_drop_cnt;
  assign idx_err   = r_idx_err;

endmodule : bl_zone_tx_scheduler
`default_nettype wire

// File: tb/tb_bl_zone_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_bl_zone_tx_scheduler
// Description : Self-checking bench for bl_zone_tx_scheduler. A frame table
//               drives full frames; a scoreboard queue holds the expected beats
//               and a monitor compares them as the link accepts each beat.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bl_zone_tx_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       zone_valid;
  logic [8:0] zone_idx;
  logic [7:0] zone_data;
  logic       vsync;
  logic [1:0] mode_req;
  logic [1:0] gray_mode;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       tx_sof;
  logic       tx_eof;
  logic       busy;
  logic [7:0] drop_cnt;
  logic       idx_err;

  bl_zone_tx_scheduler dut (
    .i_pix_clk  (clk),
    .rst        (rst),
    .zone_valid (zone_valid),
    .zone_idx   (zone_idx),
    .zone_data  (zone_data),
    .vsync      (vsync),
    .mode_req   (mode_req),
    .gray_mode  (gray_mode),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_data    (tx_data),
    .tx_sof     (tx_sof),
    .tx_eof     (tx_eof),
    .busy       (busy),
    .drop_cnt   (drop_cnt),
    .idx_err    (idx_err)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    int         ready_mode;  // 0 stall, 1 always ready, 2 random
    logic [7:0] seed;        // zone data = idx[7:0] ^ seed
    logic [1:0] mode_req;
    logic [1:0] exp_mode;    // gray_mode expected after the swap
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       sof;
    logic       eof;
  } beat_t;

  vec_t       vecs [4];
  beat_t      sb_q [$];
  logic [7:0] model_mem [2][360];
  bit         model_wr;
  int         ready_mode;
  int         n_tests;
  int         n_fail;
  logic [1:0] cur_mode;
  int         exp_drop;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Link-side ready pattern
  initial begin
    tx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       tx_ready = 1'b0;
        1:       tx_ready = 1'b1;
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: beat compare against scoreboard and hold-while-stalled check
  initial begin
    bit         prev_stall;
    logic [7:0] prev_data;
    logic       prev_sof;
    logic       prev_eof;
    beat_t      b;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_sof   = 1'b0;
    prev_eof   = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("stall_hold", 32'({tx_valid, tx_data, tx_sof, tx_eof}),
              32'({1'b1, prev_data, prev_sof, prev_eof}));
        end
        if (tx_valid && tx_ready) begin
          if (sb_q.size() == 0) begin
            chk("extra_beat", 32'(tx_data), 32'hFFFF_FFFF);
          end else begin
            b = sb_q.pop_front();
            chk("beat", 32'({tx_data, tx_sof, tx_eof}), 32'({b.data, b.sof, b.eof}));
          end
        end
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
        prev_sof   = tx_sof;
        prev_eof   = tx_eof;
      end
    end
  end

  // Watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic write_zone(input logic [8:0] idx, input logic [7:0] d);
    zone_valid = 1'b1;
    zone_idx   = idx;
    zone_data  = d;
    if (idx < 9'd360) model_mem[model_wr][idx] = d;
    @(posedge clk);
    #1;
    zone_valid = 1'b0;
  endtask

  task automatic write_frame(input logic [7:0] seed);
    for (int i = 0; i < 360; i++) write_zone(9'(i), 8'(i) ^ seed);
  endtask

  task automatic push_frame();
    for (int i = 0; i < 360; i++) sb_q.push_back('{model_mem[model_wr][i], i == 0, i == 359});
  endtask

  // Rising vsync edge; optional zone write in the same cycle
  task automatic frame_edge(input logic [1:0] old_mode, input logic [1:0] new_mode,
                            input bit swap, input bit cw, input logic [8:0] cw_idx,
                            input logic [7:0] cw_data);
    vsync = 1'b1;
    if (cw) begin
      zone_valid = 1'b1;
      zone_idx   = cw_idx;
      zone_data  = cw_data;
      model_mem[model_wr][cw_idx] = cw_data;
    end
    if (swap) begin
      push_frame();
      model_wr = ~model_wr;
    end
    @(negedge clk);
    chk("mode_at_edge", 32'(gray_mode), 32'(old_mode));
    @(posedge clk);
    #1;
    zone_valid = 1'b0;
    @(negedge clk);
    chk("mode_after_edge", 32'(gray_mode), 32'(new_mode));
    chk("drop_cnt_edge", 32'(drop_cnt), 32'(exp_drop));
    chk("busy_after_edge", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    if (swap) chk("first_beat_latency", 32'(tx_valid), 32'd1);
    @(posedge clk);
    #1;
    vsync = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (!busy && sb_q.size() == 0) break;
    end
    chk("idle_after_frame", 32'(busy), 32'd0);
    chk("queue_drained", 32'(sb_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    model_wr   = 1'b0;
    exp_drop   = 0;
    cur_mode   = 2'b11;
    ready_mode = 1;
    rst        = 1'b1;
    zone_valid = 1'b0;
    zone_idx   = '0;
    zone_data  = '0;
    vsync      = 1'b0;
    mode_req   = 2'b11;

    vecs[0] = '{1, 8'h00, 2'b11, 2'b11};  // basic frame, data = idx[7:0]
    vecs[1] = '{2, 8'h00, 2'b11, 2'b11};  // same frame, random backpressure
    vecs[2] = '{1, 8'h5A, 2'b01, 2'b01};  // mode change to opt at boundary
    vecs[3] = '{2, 8'hA5, 2'b10, 2'b10};  // mode change to static

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gray_mode", 32'(gray_mode), 32'h3);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_outs", 32'({tx_data, tx_sof, tx_eof, busy, drop_cnt, idx_err}), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Table-driven frames
    for (int v = 0; v < 4; v++) begin
      ready_mode = vecs[v].ready_mode;
      mode_req   = vecs[v].mode_req;
      write_frame(vecs[v].seed);
      chk("mode_hold_before_edge", 32'(gray_mode), 32'(cur_mode));
      frame_edge(cur_mode, vecs[v].exp_mode, 1'b1, 1'b0, '0, '0);
      cur_mode = vecs[v].exp_mode;
      wait_idle();
      chk("no_drop", 32'(drop_cnt), 32'd0);
      chk("no_idx_err", 32'(idx_err), 32'd0);
    end

    // Boundary while streaming: dropped, no swap, mode unchanged
    ready_mode = 0;
    mode_req   = 2'b01;
    write_frame(8'h33);
    frame_edge(cur_mode, 2'b01, 1'b1, 1'b0, '0, '0);
    cur_mode = 2'b01;
    repeat (3) @(posedge clk);
    #1;
    mode_req = 2'b11;
    exp_drop = 1;
    frame_edge(cur_mode, cur_mode, 1'b0, 1'b0, '0, '0);
    chk("drop_one", 32'(drop_cnt), 32'd1);
    for (int k = 0; k < 260; k++) begin
      vsync = 1'b1;
      @(posedge clk);
      #1;
      vsync = 1'b0;
      @(posedge clk);
      #1;
    end
    chk("drop_saturate", 32'(drop_cnt), 32'd255);
    chk("mode_kept_on_drop", 32'(gray_mode), 32'(cur_mode));
    exp_drop   = 255;
    ready_mode = 2;
    wait_idle();

    // Out-of-range index and write coincident with the boundary
    ready_mode = 1;
    mode_req   = cur_mode;
    write_frame(8'h77);
    write_zone(9'd360, 8'hEE);
    chk("idx_err_set", 32'(idx_err), 32'd1);
    frame_edge(cur_mode, cur_mode, 1'b1, 1'b1, 9'd7, 8'hC3);
    wait_idle();
    chk("idx_err_sticky", 32'(idx_err), 32'd1);

    // Asynchronous reset during HOLD
    ready_mode = 0;
    mode_req   = 2'b10;
    write_frame(8'h11);
    frame_edge(cur_mode, 2'b10, 1'b1, 1'b0, '0, '0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_mid_drop", 32'(drop_cnt), 32'd0);
    chk("rst_mid_mode", 32'(gray_mode), 32'h3);
    chk("rst_mid_state", 32'({busy, idx_err, tx_sof, tx_eof}), 32'd0);
    sb_q.delete();
    model_wr = 1'b0;
    cur_mode = 2'b11;
    exp_drop = 0;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Fresh frame after reset
    ready_mode = 1;
    mode_req   = 2'b11;
    write_frame(8'h99);
    frame_edge(cur_mode, 2'b11, 1'b1, 1'b0, '0, '0);
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_bl_zone_tx_scheduler
`default_nettype wire
